// File: rtl/display_scan_controller_if.sv
// Processor-side and driver-side signals of the display scan controller.
// master drives scan control and frame data; slave is the controller itself.
interface display_scan_controller_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    scan_en;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] data_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic                    load_ack;
  logic [3:0]              digit_code;
  logic [NUM_DIGITS-1:0]   digit_en_n;

  modport master (
    output scan_en, load, data_in, blank_in,
    input  load_ack, digit_code, digit_en_n
  );

  modport slave (
    input  scan_en, load, data_in, blank_in,
    output load_ack, digit_code, digit_en_n
  );
endinterface

// File: rtl/display_scan_controller.sv
// Multiplexed BCD display scanner with blanking gaps between digits and a
// double-buffered frame that is only swapped in when the scan wraps to digit 0.
module display_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  display_scan_controller_if.slave bus
);
  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int DATA_W  = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   boundary;
  logic                   commit;

  logic                   pending_q, pending_d;
  logic [DATA_W-1:0]      pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0]  pend_blank_q, pend_blank_d;
  logic [DATA_W-1:0]      shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]  shadow_blank_q, shadow_blank_d;

  logic [NUM_DIGITS-1:0]  digit_en_n_q, digit_en_n_d;
  logic [3:0]             digit_code_q, digit_code_d;
  logic                   load_ack_q, load_ack_d;

  // Scan sequencer: blank gap, then lit slot, advancing digit index; scan_en low parks in BLANK.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    boundary = 1'b0;
    if (!bus.scan_en) begin
      state_d = ST_BLANK;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d    = '0;
              boundary = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_BLANK;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Frame buffer: commit uses the pending data as it stood before this edge,
  // so a load landing on the boundary edge waits for the next frame.
  always_comb begin
    commit         = boundary & pending_q;
    pending_d      = pending_q;
    pend_data_d    = pend_data_q;
    pend_blank_d   = pend_blank_q;
    shadow_d       = shadow_q;
    shadow_blank_d = shadow_blank_q;
    if (commit) begin
      shadow_d       = pend_data_q;
      shadow_blank_d = pend_blank_q;
      pending_d      = 1'b0;
    end else begin
      shadow_d       = shadow_q;
      shadow_blank_d = shadow_blank_q;
    end
    if (bus.load) begin
      pending_d    = 1'b1;
      pend_data_d  = bus.data_in;
      pend_blank_d = bus.blank_in;
    end else begin
      pend_data_d  = pend_data_q;
      pend_blank_d = pend_blank_q;
    end
  end

  // Output decode from next-state values so outputs move on the same edge as the state.
  always_comb begin
    digit_en_n_d = '1;
    digit_code_d = 4'hF;
    load_ack_d   = commit;
    if ((state_d == ST_SHOW) && !shadow_blank_d[idx_d]) begin
      digit_en_n_d = ~(NUM_DIGITS'(1) << idx_d);
      digit_code_d = shadow_d[{idx_d, 2'b00} +: 4];
    end else begin
      digit_en_n_d = '1;
      digit_code_d = 4'hF;
    end
  end

  // State, frame buffer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_BLANK;
      cnt_q          <= '0;
      idx_q          <= '0;
      pending_q      <= 1'b0;
      pend_data_q    <= '0;
      pend_blank_q   <= '0;
      shadow_q       <= '1;
      shadow_blank_q <= '1;
      digit_en_n_q   <= '1;
      digit_code_q   <= 4'hF;
      load_ack_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      pending_q      <= pending_d;
      pend_data_q    <= pend_data_d;
      pend_blank_q   <= pend_blank_d;
      shadow_q       <= shadow_d;
      shadow_blank_q <= shadow_blank_d;
      digit_en_n_q   <= digit_en_n_d;
      digit_code_q   <= digit_code_d;
      load_ack_q     <= load_ack_d;
    end
  end

  assign bus.digit_en_n = digit_en_n_q;
  assign bus.digit_code = digit_code_q;
  assign bus.load_ack   = load_ack_q;
endmodule
